// File: rtl/of_input_arbiter_if.sv
// AXI4-Stream bundle shared by the five ingress ports and the merged egress stream.
interface of_input_arbiter_if #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128
);
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] tstrb;
    logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                           tvalid;
    logic                           tready;
    logic                           tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/of_input_arbiter.sv
// Packet-granular round-robin merge of five ingress AXI4-Stream ports into one
// registered 64-bit stream. A granted port keeps the output until its tlast beat.
// Optional feature: define OF_IN_ARB_SPT_STAMP_EN to overwrite tuser[23:16] on the
// first beat of every packet with a one-hot mask of the granted port.
module of_input_arbiter #(
    parameter int unsigned C_AXIS_DATA_WIDTH     = 64,
    parameter int unsigned C_AXIS_TUSER_WIDTH    = 128,
    parameter int unsigned C_AXIS_SPT_DATA_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    of_input_arbiter_if.slave    s_axis_0,
    of_input_arbiter_if.slave    s_axis_1,
    of_input_arbiter_if.slave    s_axis_2,
    of_input_arbiter_if.slave    s_axis_3,
    of_input_arbiter_if.slave    s_axis_4,
    of_input_arbiter_if.master   m_axis
);
    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PW        = 3;
    localparam int unsigned DW        = C_AXIS_DATA_WIDTH;
    localparam int unsigned SW        = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW        = C_AXIS_TUSER_WIDTH;
    localparam int unsigned SPT_W     = C_AXIS_SPT_DATA_WIDTH;
    localparam int unsigned SPT_LO    = 16;

    typedef enum logic [0:0] {ST_IDLE, ST_PKT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   last_q, last_d;
    logic [PW-1:0]   pick_c;

    logic [NUM_PORTS-1:0] in_valid, in_last, in_ready_c;
    logic [DW-1:0]        in_data [NUM_PORTS];
    logic [SW-1:0]        in_strb [NUM_PORTS];
    logic [UW-1:0]        in_user [NUM_PORTS];

    logic                 g_valid, g_last;
    logic [DW-1:0]        g_data;
    logic [SW-1:0]        g_strb;
    logic [UW-1:0]        g_user;
    logic [UW-1:0]        user_c;
    logic [SPT_W-1:0]     spt_c;
    logic                 out_ready_c, load_c;

    logic                 m_valid_q, m_last_q;
    logic [DW-1:0]        m_data_q;
    logic [SW-1:0]        m_strb_q;
    logic [UW-1:0]        m_user_q;

    // Flatten the five port bundles into indexable arrays.
    assign {in_valid[0], in_last[0], in_data[0], in_strb[0], in_user[0]} =
           {s_axis_0.tvalid, s_axis_0.tlast, s_axis_0.tdata, s_axis_0.tstrb, s_axis_0.tuser};
    assign {in_valid[1], in_last[1], in_data[1], in_strb[1], in_user[1]} =
           {s_axis_1.tvalid, s_axis_1.tlast, s_axis_1.tdata, s_axis_1.tstrb, s_axis_1.tuser};
    assign {in_valid[2], in_last[2], in_data[2], in_strb[2], in_user[2]} =
           {s_axis_2.tvalid, s_axis_2.tlast, s_axis_2.tdata, s_axis_2.tstrb, s_axis_2.tuser};
    assign {in_valid[3], in_last[3], in_data[3], in_strb[3], in_user[3]} =
           {s_axis_3.tvalid, s_axis_3.tlast, s_axis_3.tdata, s_axis_3.tstrb, s_axis_3.tuser};
    assign {in_valid[4], in_last[4], in_data[4], in_strb[4], in_user[4]} =
           {s_axis_4.tvalid, s_axis_4.tlast, s_axis_4.tdata, s_axis_4.tstrb, s_axis_4.tuser};

    assign s_axis_0.tready = in_ready_c[0];
    assign s_axis_1.tready = in_ready_c[1];
    assign s_axis_2.tready = in_ready_c[2];
    assign s_axis_3.tready = in_ready_c[3];
    assign s_axis_4.tready = in_ready_c[4];

    // Round-robin pick: first valid port scanning upward from last+1, last winner scanned last.
    always_comb begin : arb_pick
        logic found;
        pick_c = last_q;
        found  = 1'b0;
        for (int k = 1; k <= int'(NUM_PORTS); k++) begin
            if (!found && in_valid[(int'(last_q) + k) % int'(NUM_PORTS)]) begin
                pick_c = PW'((int'(last_q) + k) % int'(NUM_PORTS));
                found  = 1'b1;
            end
        end
    end

    // Mux the granted port's beat.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        g_strb  = '0;
        g_user  = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant_q == PW'(i)) begin
                g_valid = in_valid[i];
                g_last  = in_last[i];
                g_data  = in_data[i];
                g_strb  = in_strb[i];
                g_user  = in_user[i];
            end
        end
    end

    // Output slot can take a beat when empty or draining this cycle.
    assign out_ready_c = !m_valid_q || m_axis.tready;

    // Next-state, grant bookkeeping and input ready.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        in_ready_c = '0;
        load_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|in_valid) begin
                    grant_d = pick_c;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                // Ready is held low while reset is asserted so no beat is taken and then discarded.
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    if (grant_q == PW'(i)) in_ready_c[i] = out_ready_c && aresetn;
                end
                load_c = out_ready_c && g_valid;
                if (load_c && g_last) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and grant state registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef OF_IN_ARB_SPT_STAMP_EN
    logic first_q;

    // Marks the next accepted beat as the first of its packet.
    always_ff @(posedge aclk) begin
        if (!aresetn)                first_q <= 1'b1;
        else if (state_q == ST_IDLE) first_q <= 1'b1;
        else if (load_c)             first_q <= 1'b0;
    end
`endif

    // Source-port field: pass through, or one-hot grant stamp on the first beat.
    always_comb begin
        spt_c = g_user[SPT_LO +: SPT_W];
`ifdef OF_IN_ARB_SPT_STAMP_EN
        if (first_q) spt_c = SPT_W'(1) << grant_q;
`endif
        user_c = g_user;
        user_c[SPT_LO +: SPT_W] = spt_c;
    end

    // Registered output slot: load on input handshake, clear valid on drain without load.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_strb_q  <= '0;
            m_user_q  <= '0;
        end else if (load_c) begin
            m_valid_q <= 1'b1;
            m_last_q  <= g_last;
            m_data_q  <= g_data;
            m_strb_q  <= g_strb;
            m_user_q  <= user_c;
        end else if (m_valid_q && m_axis.tready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tstrb  = m_strb_q;
    assign m_axis.tuser  = m_user_q;
endmodule

// File: tb/tb_of_input_arbiter.sv
// Directed bench for of_input_arbiter: cycle table plus hand sequences for stamp and mid-packet reset.
module tb_of_input_arbiter;
    logic       aclk = 1'b0;
    logic       aresetn;
    logic [4:0] vld, lst, rdy;
    logic       m_rdy;
    logic [63:0]  dat [5];
    logic [127:0] usr [5];
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rstn;
        logic [4:0]  vld;
        logic [4:0]  lst;
        logic        mrdy;
        logic [7:0]  tag;
        logic [4:0]  e_rdy;
        logic        e_mv;
        logic        e_last;
        logic [15:0] e_dat;
    } vec_t;

    vec_t tbl[$];

    of_input_arbiter_if s_if [5] ();
    of_input_arbiter_if m_if ();

    for (genvar i = 0; i < 5; i++) begin : g_drv
        assign s_if[i].tvalid = vld[i];
        assign s_if[i].tlast  = lst[i];
        assign s_if[i].tdata  = dat[i];
        assign s_if[i].tstrb  = 8'hFF;
        assign s_if[i].tuser  = usr[i];
        assign rdy[i]         = s_if[i].tready;
    end
    assign m_if.tready = m_rdy;

    of_input_arbiter dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_axis_0 (s_if[0]),
        .s_axis_1 (s_if[1]),
        .s_axis_2 (s_if[2]),
        .s_axis_3 (s_if[3]),
        .s_axis_4 (s_if[4]),
        .m_axis   (m_if)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then settle before checking.
    task automatic apply(input logic r, input logic [4:0] v, input logic [4:0] l,
                         input logic mr, input logic [7:0] tag);
        @(posedge aclk);
        #1;
        aresetn = r;
        vld     = v;
        lst     = l;
        m_rdy   = mr;
        for (int i = 0; i < 5; i++) dat[i] = {48'h0, tag, 8'(i)};
        #2;
    endtask

    task automatic add(input logic r, input logic [4:0] v, input logic [4:0] l, input logic mr,
                       input logic [7:0] t, input logic [4:0] er, input logic emv,
                       input logic eml, input logic [15:0] ed);
        tbl.push_back('{r, v, l, mr, t, er, emv, eml, ed});
    endtask

    task automatic build_tbl();
        int p;
        // Reset held with every port requesting, then release.
        for (int n = 0; n < 4; n++) add(1'b0, 5'h1F, 5'h00, 1'b1, 8'd0, 5'h00, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h1F, 5'h00, 1'b1, 8'd0, 5'h00, 1'b0, 1'b0, 16'h0);
        // Round robin of 3-beat packets: 0,1,2,3,4,0, one-cycle gap each.
        for (int n = 0; n < 6; n++) begin
            p = n % 5;
            add(1'b1, 5'h1F, 5'h00, 1'b1, 8'd1, 5'(1 << p), 1'b0, 1'b0, 16'h0);
            add(1'b1, 5'h1F, 5'h00, 1'b1, 8'd2, 5'(1 << p), 1'b1, 1'b0, {8'd1, 8'(p)});
            add(1'b1, 5'h1F, 5'h1F, 1'b1, 8'd3, 5'(1 << p), 1'b1, 1'b0, {8'd2, 8'(p)});
            add(1'b1, 5'h1F, 5'h00, 1'b1, 8'd0, 5'h00,      1'b1, 1'b1, {8'd3, 8'(p)});
        end
        // Backpressure: m_tready 1,0,0,1 during a 4-beat port-0 packet.
        for (int n = 0; n < 2; n++) add(1'b0, 5'h00, 5'h00, 1'b1, 8'd0, 5'h00, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h01, 5'h00, 1'b1, 8'd1, 5'h00, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h01, 5'h00, 1'b1, 8'd1, 5'h01, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h01, 5'h00, 1'b1, 8'd2, 5'h01, 1'b1, 1'b0, 16'h0100);
        add(1'b1, 5'h01, 5'h00, 1'b0, 8'd3, 5'h00, 1'b1, 1'b0, 16'h0200);
        add(1'b1, 5'h01, 5'h00, 1'b0, 8'd3, 5'h00, 1'b1, 1'b0, 16'h0200);
        add(1'b1, 5'h01, 5'h00, 1'b1, 8'd3, 5'h01, 1'b1, 1'b0, 16'h0200);
        add(1'b1, 5'h01, 5'h01, 1'b1, 8'd4, 5'h01, 1'b1, 1'b0, 16'h0300);
        add(1'b1, 5'h00, 5'h00, 1'b1, 8'd0, 5'h00, 1'b1, 1'b1, 16'h0400);
        add(1'b1, 5'h00, 5'h00, 1'b1, 8'd0, 5'h00, 1'b0, 1'b0, 16'h0);
        // No interleave: 6-beat port-2 packet, port 1 raises valid at beat 2, then port 1 single beat.
        for (int n = 0; n < 2; n++) add(1'b0, 5'h00, 5'h00, 1'b1, 8'd0, 5'h00, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h04, 5'h00, 1'b1, 8'd1, 5'h00, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h04, 5'h00, 1'b1, 8'd1, 5'h04, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h06, 5'h00, 1'b1, 8'd2, 5'h04, 1'b1, 1'b0, 16'h0102);
        add(1'b1, 5'h06, 5'h00, 1'b1, 8'd3, 5'h04, 1'b1, 1'b0, 16'h0202);
        add(1'b1, 5'h06, 5'h00, 1'b1, 8'd4, 5'h04, 1'b1, 1'b0, 16'h0302);
        add(1'b1, 5'h06, 5'h00, 1'b1, 8'd5, 5'h04, 1'b1, 1'b0, 16'h0402);
        add(1'b1, 5'h06, 5'h04, 1'b1, 8'd6, 5'h04, 1'b1, 1'b0, 16'h0502);
        add(1'b1, 5'h02, 5'h00, 1'b1, 8'd1, 5'h00, 1'b1, 1'b1, 16'h0602);
        add(1'b1, 5'h02, 5'h02, 1'b1, 8'd1, 5'h02, 1'b0, 1'b0, 16'h0);
        add(1'b1, 5'h00, 5'h00, 1'b1, 8'd0, 5'h00, 1'b1, 1'b1, 16'h0101);
        add(1'b1, 5'h00, 5'h00, 1'b1, 8'd0, 5'h00, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [127:0] u_in, u_first;
        logic [7:0]   spt_exp;

        aresetn = 1'b0;
        vld     = 5'h1F;
        lst     = 5'h00;
        m_rdy   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat[i] = 64'(i);
            usr[i] = '0;
        end

        build_tbl();
        foreach (tbl[k]) begin
            apply(tbl[k].rstn, tbl[k].vld, tbl[k].lst, tbl[k].mrdy, tbl[k].tag);
            chk($sformatf("v%0d ready", k), 128'(rdy), 128'(tbl[k].e_rdy));
            chk($sformatf("v%0d m_tvalid", k), 128'(m_if.tvalid), 128'(tbl[k].e_mv));
            if (tbl[k].e_mv) begin
                chk($sformatf("v%0d m_tdata", k), 128'(m_if.tdata[15:0]), 128'(tbl[k].e_dat));
                chk($sformatf("v%0d m_tlast", k), 128'(m_if.tlast), 128'(tbl[k].e_last));
            end
        end

        // Source-port stamp on a 2-beat port-3 packet.
`ifdef OF_IN_ARB_SPT_STAMP_EN
        spt_exp = 8'h08;
`else
        spt_exp = 8'hAA;
`endif
        u_in    = 128'h1234_5678_9ABC_DEF0_0011_2233_44AA_0040;
        u_first = u_in;
        u_first[23:16] = spt_exp;
        usr[3]  = u_in;
        apply(1'b0, 5'h00, 5'h00, 1'b1, 8'd0);
        apply(1'b0, 5'h00, 5'h00, 1'b1, 8'd0);
        apply(1'b1, 5'h08, 5'h00, 1'b1, 8'd1);
        chk("stamp idle ready", 128'(rdy), 128'(5'h00));
        apply(1'b1, 5'h08, 5'h00, 1'b1, 8'd1);
        chk("stamp grant ready", 128'(rdy), 128'(5'h08));
        apply(1'b1, 5'h08, 5'h08, 1'b1, 8'd2);
        chk("stamp beat1 valid", 128'(m_if.tvalid), 128'(1'b1));
        chk("stamp beat1 tuser", m_if.tuser, u_first);
        chk("stamp beat1 tdata", 128'(m_if.tdata), 128'(64'h0103));
        apply(1'b1, 5'h00, 5'h00, 1'b1, 8'd0);
        chk("stamp beat2 tuser", m_if.tuser, u_in);
        chk("stamp beat2 tlast", 128'(m_if.tlast), 128'(1'b1));
        chk("stamp beat2 tstrb", 128'(m_if.tstrb), 128'(8'hFF));
        usr[3] = '0;

        // Reset in the middle of a 5-beat port-1 packet, then port 0 wins over port 1.
        apply(1'b1, 5'h02, 5'h00, 1'b1, 8'd1);
        chk("midrst idle ready", 128'(rdy), 128'(5'h00));
        apply(1'b1, 5'h02, 5'h00, 1'b1, 8'd1);
        chk("midrst grant ready", 128'(rdy), 128'(5'h02));
        apply(1'b1, 5'h02, 5'h00, 1'b1, 8'd2);
        chk("midrst beat1 data", 128'(m_if.tdata[15:0]), 128'(16'h0101));
        apply(1'b0, 5'h02, 5'h00, 1'b1, 8'd3);
        chk("midrst beat2 data", 128'(m_if.tdata[15:0]), 128'(16'h0201));
        chk("midrst ready in reset", 128'(rdy), 128'(5'h00));
        apply(1'b0, 5'h03, 5'h00, 1'b1, 8'd3);
        chk("midrst m_tvalid", 128'(m_if.tvalid), 128'(1'b0));
        chk("midrst m_tdata cleared", 128'(m_if.tdata), 128'(64'h0));
        apply(1'b1, 5'h03, 5'h00, 1'b1, 8'd1);
        chk("midrst back in idle", 128'(rdy), 128'(5'h00));
        apply(1'b1, 5'h03, 5'h00, 1'b1, 8'd1);
        chk("midrst port0 regrant", 128'(rdy), 128'(5'h01));
        apply(1'b1, 5'h03, 5'h01, 1'b1, 8'd2);
        chk("midrst port0 beat1", 128'(m_if.tdata[15:0]), 128'(16'h0100));
        apply(1'b1, 5'h00, 5'h00, 1'b1, 8'd0);
        chk("midrst port0 last data", 128'(m_if.tdata[15:0]), 128'(16'h0200));
        chk("midrst port0 tlast", 128'(m_if.tlast), 128'(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/of_input_arbiter.md
# of_input_arbiter

- Packet-granular, round-robin arbiter that merges the five ingress AXI4-Stream ports (four 10G MACs plus DMA) into the single 64-bit stream consumed by `openflow_datapath`.
- Sits between the port input queues and the datapath's lookup stage.
- Once a packet is granted it is locked until its `tlast` beat is accepted, so packets never interleave.
- The output is registered to cut the timing path from the five input queues into the datapath.

## Interface

Parameters:
- `C_AXIS_DATA_WIDTH`, 64: tdata width; `tstrb` is `C_AXIS_DATA_WIDTH/8`.
- `C_AXIS_TUSER_WIDTH`, 128: tuser width. Layout: [15:0] length, [23:16] source port, [31:24] destination port.
- `C_AXIS_SPT_DATA_WIDTH`, 8: width of the source-port field in tuser.

Ports:
- Clocking and reset: one clock, `aclk`; reset `aresetn` is synchronous and active-low.
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: synchronous active-low reset.
- `s_axis_tdata_i`, in, 64, for i = 0..4: input data.
- `s_axis_tstrb_i`, in, 8: input byte strobes.
- `s_axis_tuser_i`, in, 128: input sideband; valid on the first beat.
- `s_axis_tvalid_i`, in, 1: input valid.
- `s_axis_tready_i`, out, 1: input ready.
- `s_axis_tlast_i`, in, 1: last beat of the packet.
- `m_axis_tdata`, out, 64: merged data.
- `m_axis_tstrb`, out, 8: merged strobes.
- `m_axis_tuser`, out, 128: merged sideband.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: output ready.
- `m_axis_tlast`, out, 1: output last.

## Operation

State machine, two states:
- **IDLE**
  - All `s_axis_tready_i` = 0.
  - If any `s_axis_tvalid_i` = 1: `grant` = first valid port scanning upward from `last+1` (mod 5), then go to PKT.
  - Otherwise stay in IDLE.
- **PKT**
  - `s_axis_tready_grant = !m_axis_tvalid || m_axis_tready`. All other readies are 0.
  - Each accepted beat loads the output register.
  - If the accepted beat has `tlast` = 1: `last <= grant`, go to IDLE.

Output register:
- Loads on an input handshake.
- Clears `m_axis_tvalid` on an output handshake with no simultaneous load.
- A simultaneous load and drain is a replace, with `m_axis_tvalid` staying 1.
- Data, strb, user and last are held stable while `m_axis_tvalid && !m_axis_tready`.

Grant and fairness rules:
- Valids on non-granted ports are ignored in PKT.
- If the granted port drops `tvalid` mid-packet, the arbiter stays locked and waits; it does not time out.
- A single-beat packet (`tlast` on the first beat) is legal; the arbiter returns to IDLE after that beat.
- A port that wins is scanned last in the next arbitration.
- Each port is served at most once per five packets while all ports are requesting.

Reset:
- `m_axis_tvalid`=0; `m_axis_tdata`/`m_axis_tstrb`/`m_axis_tuser`/`m_axis_tlast`=0.
- All `s_axis_tready_i`=0.
- State=IDLE; `last`=4, so port 0 wins first.
- Reset mid-packet discards the partial packet and the register contents. Downstream shares the reset.

## Timing

- Arbitration costs one cycle. `tvalid` seen in IDLE at edge N → PKT after N; `s_axis_tready` is high during cycle N+1; first beat accepted at edge N+1 at the earliest.
- Input-to-output latency: a beat accepted at edge N is on `m_axis_*` in cycle N+1.
- Throughput: one beat per cycle within a packet while `m_axis_tready`=1.
- Inter-packet gap: exactly one idle cycle on the input side per packet; the output shows a gap of at least one cycle.
- `s_axis_tready_grant` is combinational from `m_axis_tready` and the register state.
- No combinational path from `s_axis_tvalid` to `s_axis_tready`.

## Configuration

- Macro: `OF_IN_ARB_SPT_STAMP_EN`.
- **Defined:** on the first beat of each packet, `m_axis_tuser[23:16]` is overwritten with `8'h01 << grant`. All other tuser bits pass through.
- **Undefined:** tuser passes through unmodified on every beat.

## Test plan

1. **Reset state:** hold `aresetn`=0 for 4 cycles with all `tvalid`=1 → every `s_axis_tready_i`=0 and `m_axis_tvalid`=0 throughout. After release, port 0 is granted first.
2. **Round-robin:** all five ports continuously offer 3-beat packets with `m_axis_tready`=1 → output grant order 0,1,2,3,4,0; each packet occupies 3 output beats followed by a 1-cycle gap.
3. **No interleave:** port 2 sends a 6-beat packet, and port 1 raises `tvalid` at beat 2 → all 6 port-2 beats are contiguous on the output, then port 3 is skipped (idle) and port 1 is served next.
4. **Backpressure:** `m_axis_tready` toggles 1,0,0,1 during a 4-beat packet → no beat is lost or duplicated, output data is stable while stalled, and the `tdata` sequence matches the input.
5. **Source-port stamp:** with `OF_IN_ARB_SPT_STAMP_EN` defined, a port-3 packet with input `tuser[23:16]`=8'hAA → the first output beat has `tuser[23:16]`=8'h08. With the macro undefined, the output value is 8'hAA.
6. **Reset mid-packet:** assert reset at beat 2 of 5 → next cycle `m_axis_tvalid`=0 and the FSM is in IDLE. Port 0 is then re-granted cleanly after release.
